// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, PPROT bit positions and
// default widths/timeout used by both master and slave sides.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int PROT_PRIV_BIT  = 0;
  localparam int PROT_NSEC_BIT  = 1;
  localparam int PROT_INSTR_BIT = 2;

  localparam int APB_DEF_DATA_WIDTH = 32;
  localparam int APB_DEF_STRB_WIDTH = APB_DEF_DATA_WIDTH / 8;
  localparam int APB_DEF_TIMEOUT    = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired flags the last allowed
// wait cycle. A TIMEOUT_CYCLES of 0 never expires.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_DEF_TIMEOUT
) (
  input  logic apb_clk_in,
  input  logic apb_rstn_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{apb_clk_in, apb_rstn_in, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt_q;

      always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (enable) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_if.sv
// APB master front end: one command at a time through
// SETUP/ACCESS with bounded PREADY wait, response over valid/ready.
module apb_master_if
  import apb_pkg::*;
#(
  parameter  int APB_ADDR_WIDTH = 32,
  parameter  int APB_DATA_WIDTH = APB_DEF_DATA_WIDTH,
  parameter  int TIMEOUT_CYCLES = APB_DEF_TIMEOUT,
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rstn_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic                      cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
  input  logic [APB_STRB_WIDTH-1:0] cmd_strb_in,
  input  logic [2:0]                cmd_prot_in,
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_error_out,
  output logic                      rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  output logic [APB_STRB_WIDTH-1:0] apb_strb_out,
  output logic [2:0]                apb_prot_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  apb_state_e state_q, state_d;

  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [APB_STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;
  logic                      psel_q, psel_d;
  logic                      pen_q, pen_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      to_q, to_d;

  logic cnt_clr;
  logic cnt_en;
  logic expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .apb_clk_in  (apb_clk_in),
    .apb_rstn_in (apb_rstn_in),
    .clear       (cnt_clr),
    .enable      (cnt_en),
    .expired     (expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prot_d   = prot_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (cmd_valid_in) begin
          addr_d  = cmd_addr_in;
          write_d = cmd_write_in;
          wdata_d = cmd_write_in ? cmd_wdata_in : '0;
          strb_d  = cmd_write_in ? cmd_strb_in : '0;
          prot_d  = cmd_prot_in;
          psel_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      (state_q == ST_SETUP): begin
        pen_d   = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_ACCESS;
      end
      (state_q == ST_ACCESS): begin
        // PREADY takes priority over an expiring counter
        if (apb_ready_in) begin
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = write_q ? '0 : apb_rdata_in;
          err_d    = apb_slverr_in;
          to_d     = 1'b0;
          state_d  = ST_RESP;
        end else if (expired) begin
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          to_d     = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      (state_q == ST_RESP): begin
        if (rsp_ready_in) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        psel_d   = 1'b0;
        pen_d    = 1'b0;
        rvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prot_q   <= prot_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign cmd_ready_out   = (state_q == ST_IDLE);
  assign rsp_valid_out   = rvalid_q;
  assign rsp_rdata_out   = rdata_q;
  assign rsp_error_out   = err_q;
  assign rsp_timeout_out = to_q;
  assign apb_addr_out    = addr_q;
  assign apb_psel_out    = psel_q;
  assign apb_penable_out = pen_q;
  assign apb_write_out   = write_q;
  assign apb_wdata_out   = wdata_q;
  assign apb_strb_out    = strb_q;
  assign apb_prot_out    = prot_q;

endmodule

// File: tb/tb_apb_master_if.sv
// Directed bench for apb_master_if with a small
// configurable wait-state APB slave model.
module tb_apb_master_if;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] apb_addr;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic [3:0]  apb_strb;
  logic [2:0]  apb_prot;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_slverr;

  int          n_cmp = 0;
  int          n_bad = 0;

  int          slv_waits = 0;
  bit          slv_err_rdy = 1'b0;
  bit          slv_err_early = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          wcnt;

  always #5 clk = ~clk;

  apb_master_if #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .apb_clk_in      (clk),
    .apb_rstn_in     (rstn),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_addr_in     (cmd_addr),
    .cmd_write_in    (cmd_write),
    .cmd_wdata_in    (cmd_wdata),
    .cmd_strb_in     (cmd_strb),
    .cmd_prot_in     (cmd_prot),
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_error_out   (rsp_error),
    .rsp_timeout_out (rsp_timeout),
    .apb_addr_out    (apb_addr),
    .apb_psel_out    (apb_psel),
    .apb_penable_out (apb_penable),
    .apb_write_out   (apb_write),
    .apb_wdata_out   (apb_wdata),
    .apb_strb_out    (apb_strb),
    .apb_prot_out    (apb_prot),
    .apb_rdata_in    (apb_rdata),
    .apb_ready_in    (apb_ready),
    .apb_slverr_in   (apb_slverr)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) wcnt <= 0;
    else if (!apb_penable) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign apb_ready  = apb_penable && (wcnt == slv_waits);
  assign apb_rdata  = slv_rdata;
  assign apb_slverr = slv_err_rdy ? apb_ready :
    (slv_err_early && apb_penable && !apb_ready);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input bit wr,
                      input logic [31:0] addr, wdata,
                      input logic [3:0] strb,
                      input logic [2:0] prot,
                      input int waits, input bit erdy, eearly,
                      input logic [31:0] rdata,
                      input int e_lat, e_pen,
                      input bit e_err, e_to,
                      input logic [31:0] e_rdata,
                      input bit consume);
    int lat = 0;
    int ps = 0;
    int pe = 0;
    int bad = 0;
    logic [31:0] ew;
    logic [3:0]  es;
    ew = wr ? wdata : 32'h0;
    es = wr ? strb : 4'h0;
    slv_waits = waits;
    slv_err_rdy = erdy;
    slv_err_early = eearly;
    slv_rdata = rdata;
    cmd_addr = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    cmd_strb = strb;
    cmd_prot = prot;
    cmd_valid = 1'b1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
      cmd_valid = 1'b0;
      if (apb_psel) begin
        ps++;
        if (apb_addr !== addr || apb_write !== wr ||
            apb_wdata !== ew || apb_strb !== es ||
            apb_prot !== prot)
          bad++;
      end
      if (apb_penable) pe++;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_psel_cyc"}, ps, e_pen + 1);
    chk({tag, "_pen_cyc"}, pe, e_pen);
    chk({tag, "_bus_stable"}, bad, 0);
    chk({tag, "_psel_drop"}, apb_psel, 0);
    chk({tag, "_error"}, rsp_error, e_err);
    chk({tag, "_timeout"}, rsp_timeout, e_to);
    chk({tag, "_rdata"}, rsp_rdata, e_rdata);
    if (consume) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_clr"}, rsp_valid, 0);
      chk({tag, "_idle"}, cmd_ready, 1);
    end
  endtask

  initial begin
    int n;
    int spur;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb = '0;
    cmd_prot = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_psel", apb_psel, 0);
    chk("rst_pen", apb_penable, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", {rsp_error, rsp_timeout}, 0);
    chk("rst_bus", apb_addr | apb_wdata, 0);
    chk("rst_ctrl", {apb_write, apb_strb, apb_prot}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;
    tick();

    xfer("wr0", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF,
         3'(1 << PROT_NSEC_BIT), 0, 1'b0, 1'b0,
         32'hAAAA5555, 3, 1, 1'b0, 1'b0, 32'h0, 1'b1);

    xfer("rd3", 1'b0, 32'h84, 32'hFFFF0000, 4'hF,
         3'b001, 3, 1'b0, 1'b0,
         32'h12345678, 6, 4, 1'b0, 1'b0, 32'h12345678, 1'b1);

    xfer("rd_early", 1'b0, 32'h88, 32'h0, 4'h0,
         3'b000, 2, 1'b0, 1'b1,
         32'h0BADF00D, 5, 3, 1'b0, 1'b0, 32'h0BADF00D, 1'b1);

    xfer("rd_slverr", 1'b0, 32'h8C, 32'h0, 4'h0,
         3'b100, 1, 1'b1, 1'b0,
         32'hCAFE0001, 4, 2, 1'b1, 1'b0, 32'hCAFE0001, 1'b1);

    xfer("tmo", 1'b0, 32'h90, 32'h0, 4'h0,
         3'b000, 1000, 1'b0, 1'b0,
         32'h55555555, 18, 16, 1'b1, 1'b1, 32'h0, 1'b1);

    xfer("tmo_edge", 1'b0, 32'h94, 32'h0, 4'h0,
         3'b000, 15, 1'b0, 1'b0,
         32'h77778888, 18, 16, 1'b0, 1'b0, 32'h77778888, 1'b1);

    xfer("bp", 1'b0, 32'h100, 32'h0, 4'h0,
         3'b000, 0, 1'b0, 1'b0,
         32'h5A5A0F0F, 3, 1, 1'b0, 1'b0, 32'h5A5A0F0F, 1'b0);
    slv_rdata = 32'h13579BDF;
    cmd_addr = 32'h200;
    cmd_write = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rvalid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h5A5A0F0F);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_clr", rsp_valid, 0);
    chk("bp_ready2", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("bp_psel2", apb_psel, 1);
    chk("bp_addr2", apb_addr, 32'h200);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_lat2", n, 2);
    chk("bp_rdata2", rsp_rdata, 32'h13579BDF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    slv_waits = 1000;
    cmd_addr = 32'h300;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_pen", apb_penable, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_psel", apb_psel, 0);
    chk("arst_pen", apb_penable, 0);
    chk("arst_rvalid", rsp_valid, 0);
    tick();
    #2;
    rstn = 1'b1;
    spur = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || apb_psel) spur++;
    end
    chk("arst_spurious", spur, 0);
    chk("arst_cmd_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
